trap_handler: RTL and testbench
===============================

# trap_handler

Commit-side trap sequencer sitting directly downstream of the ROB commit port and upstream of the CSR file and fetch redirect. It accepts a committing exception, a committing `mret`, or a pending machine/supervisor interrupt at an instruction boundary, and selects exactly one winner. It produces a packed `trapInfo_t` (cause, epc, tval) write to the CSRs and squashes the backend. Once the backend drains, it issues a single redirect PC to fetch, computed from `mtvec` or `mepc`.

## Interface
- `DRAIN_TIMEOUT`, 1023: cycles allowed in FLUSH before `o_hang` asserts.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-low reset.
- `i_exc_vld`  in  1  ROB head commits with exception.
- `i_exc_cause`  in  16  `rv_trap_t::exception` code.
- `i_exc_epc`, `i_exc_tval`  in  XLEN  faulting pc and tval.
- `i_mret_vld`  in  1  ROB head commits `mret`.
- `i_head_vld`  in  1  ROB head valid; interrupt boundary allowed.
- `i_head_pc`  in  XLEN  pc of ROB head; epc for interrupts.
- `i_mip`, `i_mie`  in  16  pending/enable bits, indexed by interrupt code.
- `i_mstatus_mie`  in  1  global M interrupt enable.
- `i_mtvec`  in  XLEN  bits[1:0] mode, rest base.
- `i_mepc`  in  XLEN  mret target.
- `i_backend_idle`  in  1  all inflight ops drained.
- `i_redirect_rdy`  in  1  fetch accepts redirect.
- `o_block_commit`  out  1  ROB must not commit; high whenever state is not IDLE.
- `o_squash`  out  1  one-cycle backend flush pulse.
- `o_trap_wr`  out  1  one-cycle CSR trap-write strobe.
- `o_trap_is_intr`  out  1  qualifies `o_trap_wr`.
- `o_trap_info`  out  `trapInfo_t`  cause/epc/tval.
- `o_mret_done`  out  1  one-cycle pulse; CSR restores mstatus.
- `o_redirect_vld`  out  1  redirect request.
- `o_redirect_pc`  out  XLEN  target.
- `o_hang`  out  1  sticky drain-timeout flag, cleared by reset only.

## Operation
- States: IDLE, FLUSH, REDIRECT.

IDLE event selection, evaluated each cycle, highest priority first:
1. `i_exc_vld`.
2. `i_mret_vld`.
3. Interrupt, taken when `i_head_vld` and `i_mstatus_mie` and `(i_mip & i_mie)` is nonzero.
   - Interrupt priority order: mExter(11) > mSoft(3) > mTimer(7) > sExter(9) > sSoft(1) > sTimer(5).
   - Bits other than these six are ignored.

On an accepted event:
- The next cycle pulses `o_squash`.
- Exception: also pulses `o_trap_wr` with `cause=i_exc_cause`, `epc=i_exc_epc`, `tval=i_exc_tval`, `is_intr=0`.
- Interrupt: also pulses `o_trap_wr` with `cause=code`, `epc=i_head_pc`, `tval=0`, `is_intr=1`.
- `mret`: also pulses `o_mret_done`; no trap write.
- The target PC is latched at accept. Exception target is `mtvec&~3`. Interrupt target follows Configuration. `mret` target is `i_mepc`.
- State moves to FLUSH.

FLUSH:
- Wait for `i_backend_idle`, then go to REDIRECT.
- `i_backend_idle` sampled in the same cycle as `o_squash` is ignored; idle is qualified from the cycle after the pulse.
- Timeout counter increments each FLUSH cycle. Reaching `DRAIN_TIMEOUT` sets `o_hang`; the FSM keeps waiting.

REDIRECT:
- Hold `o_redirect_vld` and a stable `o_redirect_pc` until `i_redirect_rdy`, then return to IDLE.

Boundary conditions:
- Events arriving while not IDLE are ignored; the ROB is blocked. `i_exc_vld` and `i_mret_vld` in a non-IDLE state are assertion errors.
- Exception and interrupt in the same cycle: the exception wins. The interrupt is re-evaluated after return to IDLE.
- Reset mid-sequence: immediately return to IDLE; all outputs return to reset values.

## Timing
- Reset values: all outputs 0, `o_trap_info` 0, state IDLE, counter 0.
- Accept cycle T: `o_squash`, `o_trap_wr`, `o_mret_done` assert at T+1 for exactly one cycle.
- Earliest `o_redirect_vld` is T+3 (idle qualified at T+2). It stays asserted through the cycle where `i_redirect_rdy`=1, and deasserts the following cycle.
- `o_block_commit` is combinational from state: it is 0 in the accept cycle T and 1 from T+1 until the cycle after the redirect handshake.
- Back-to-back: a new event can be accepted the cycle after return to IDLE.

## Configuration
- `TRAP_VECTORED_EN` defined: interrupt target is `(mtvec&~3) + 4*cause` when `mtvec[1:0]==1`. Mode 0 gives `mtvec&~3`. Exceptions always use the base.
- Undefined: `mtvec[1:0]` is ignored; all traps target `mtvec&~3`.

## Test plan
- Exception: `i_exc_vld`, cause=2, epc=0x8000_0010, tval=0x0000_0073, mtvec=0x8000_0100, idle at T+2, rdy=1 at T+3 -> `o_trap_wr` at T+1 with those fields; `o_redirect_pc`=0x8000_0100 at T+3; back in IDLE at T+4.
- Interrupt priority: mip=mie=0x0888, mstatus_mie=1, head pc=0x8000_2000, mtvec=0x8000_0101 -> cause=11, is_intr=1, epc=0x8000_2000. Target is 0x8000_012C with `TRAP_VECTORED_EN`, 0x8000_0100 without.
- Masking: mip=0x80, mie=0x80, mstatus_mie=0 -> no outputs for 20 cycles. Setting mstatus_mie=1 -> cause=7 accepted.
- Collision: `i_exc_vld` (cause=5) with mip=mie=0x800 -> exception taken first. Interrupt (cause 11) taken after return to IDLE.
- mret: mepc=0x8000_4444 -> `o_mret_done` pulse, no `o_trap_wr`, redirect 0x8000_4444. Hold rdy=0 for 5 cycles -> vld and pc stable throughout.
- Stall/reset: `DRAIN_TIMEOUT`=8, idle held 0 -> `o_hang` after 8 FLUSH cycles. Assert `rst` low mid-FLUSH -> all outputs 0 and IDLE asynchronously.

Source files
------------

// File: rtl/trap_handler_pkg.sv
// trap_handler_pkg: shared widths and the CSR trap-write payload for trap_handler.
package trap_handler_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CAUSE_W = 16;

    // Trap record written into mcause/mepc/mtval.
    typedef struct packed {
        logic [CAUSE_W-1:0] cause;
        logic [XLEN-1:0]    epc;
        logic [XLEN-1:0]    tval;
    } trapInfo_t;

endpackage

// File: rtl/trap_handler.sv
// trap_handler: commit-side trap sequencer.
// Picks one event per instruction boundary (exception > mret > interrupt),
// pulses squash plus the CSR trap write or mret-done strobe, waits for the
// backend to drain, then hands a single redirect PC to fetch.
//
// Optional feature: define TRAP_VECTORED_EN to enable vectored interrupt
// targets ((mtvec & ~3) + 4*cause when mtvec[1:0] == 1).
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   i_exc_vld/cause/epc/tval      committing exception from ROB head
//   i_mret_vld                    committing mret
//   i_head_vld, i_head_pc         interrupt boundary and its epc
//   i_mip, i_mie, i_mstatus_mie   interrupt pending/enable state
//   i_mtvec, i_mepc               trap vector and mret target
//   i_backend_idle                backend drained
//   i_redirect_rdy                fetch accepts redirect
//   o_block_commit                ROB commit stall (not IDLE)
//   o_squash                      one-cycle backend flush
//   o_trap_wr, o_trap_is_intr,
//   o_trap_info                   one-cycle CSR trap write
//   o_mret_done                   one-cycle mret completion
//   o_redirect_vld, o_redirect_pc fetch redirect request
//   o_hang                        sticky drain-timeout flag
module trap_handler
    import trap_handler_pkg::*;
#(
    parameter int unsigned DRAIN_TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_exc_vld,
    input  logic [CAUSE_W-1:0] i_exc_cause,
    input  logic [XLEN-1:0]    i_exc_epc,
    input  logic [XLEN-1:0]    i_exc_tval,
    input  logic               i_mret_vld,
    input  logic               i_head_vld,
    input  logic [XLEN-1:0]    i_head_pc,
    input  logic [15:0]        i_mip,
    input  logic [15:0]        i_mie,
    input  logic               i_mstatus_mie,
    input  logic [XLEN-1:0]    i_mtvec,
    input  logic [XLEN-1:0]    i_mepc,
    input  logic               i_backend_idle,
    input  logic               i_redirect_rdy,
    output logic               o_block_commit,
    output logic               o_squash,
    output logic               o_trap_wr,
    output logic               o_trap_is_intr,
    output trapInfo_t          o_trap_info,
    output logic               o_mret_done,
    output logic               o_redirect_vld,
    output logic [XLEN-1:0]    o_redirect_pc,
    output logic               o_hang
);

    localparam int unsigned    CNT_W     = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] DRAIN_MAX = CNT_W'(DRAIN_TIMEOUT);
    // Only the six standard M/S interrupt sources participate.
    localparam logic [15:0]    INTR_MASK = 16'h0AAA;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REDIRECT
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;

    logic               block_n, squash_n, trap_wr_n, is_intr_n, mret_done_n;
    logic               redirect_vld_n, hang_n;
    trapInfo_t          info_n;
    logic [XLEN-1:0]    target_n;

    logic [15:0]        intr_pend;
    logic [CAUSE_W-1:0] intr_code;
    logic               intr_take;
    logic [XLEN-1:0]    tvec_base;
    logic [XLEN-1:0]    intr_target;

    // Fixed interrupt priority: MEI > MSI > MTI > SEI > SSI > STI.
    always_comb begin
        intr_pend = i_mip & i_mie & INTR_MASK;
        intr_code = '0;
        if (intr_pend[11])      intr_code = CAUSE_W'(11);
        else if (intr_pend[3])  intr_code = CAUSE_W'(3);
        else if (intr_pend[7])  intr_code = CAUSE_W'(7);
        else if (intr_pend[9])  intr_code = CAUSE_W'(9);
        else if (intr_pend[1])  intr_code = CAUSE_W'(1);
        else if (intr_pend[5])  intr_code = CAUSE_W'(5);
    end

    assign intr_take = i_head_vld && i_mstatus_mie && (intr_pend != 16'h0000);
    assign tvec_base = i_mtvec & ~XLEN'(3);

    // Interrupt target; exceptions always use the base.
    always_comb begin
        intr_target = tvec_base;
`ifdef TRAP_VECTORED_EN
        if (i_mtvec[1:0] == 2'b01) begin
            intr_target = tvec_base + (XLEN'(intr_code) << 2);
        end
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n        = state;
        cnt_n          = '0;
        squash_n       = 1'b0;
        trap_wr_n      = 1'b0;
        mret_done_n    = 1'b0;
        redirect_vld_n = 1'b0;
        is_intr_n      = o_trap_is_intr;
        info_n         = o_trap_info;
        target_n       = o_redirect_pc;
        hang_n         = o_hang;

        unique case (state)
            ST_IDLE: begin
                if (i_exc_vld) begin
                    state_n      = ST_FLUSH;
                    squash_n     = 1'b1;
                    trap_wr_n    = 1'b1;
                    is_intr_n    = 1'b0;
                    info_n.cause = i_exc_cause;
                    info_n.epc   = i_exc_epc;
                    info_n.tval  = i_exc_tval;
                    target_n     = tvec_base;
                end else if (i_mret_vld) begin
                    state_n     = ST_FLUSH;
                    squash_n    = 1'b1;
                    mret_done_n = 1'b1;
                    target_n    = i_mepc;
                end else if (intr_take) begin
                    state_n      = ST_FLUSH;
                    squash_n     = 1'b1;
                    trap_wr_n    = 1'b1;
                    is_intr_n    = 1'b1;
                    info_n.cause = intr_code;
                    info_n.epc   = i_head_pc;
                    info_n.tval  = '0;
                    target_n     = intr_target;
                end
            end
            ST_FLUSH: begin
                cnt_n = (cnt == DRAIN_MAX) ? cnt : cnt + CNT_W'(1);
                if (cnt_n == DRAIN_MAX) begin
                    hang_n = 1'b1;
                end
                // Idle seen alongside the squash pulse predates the flush.
                if (i_backend_idle && !o_squash) begin
                    state_n        = ST_REDIRECT;
                    redirect_vld_n = 1'b1;
                end
            end
            ST_REDIRECT: begin
                if (i_redirect_rdy) begin
                    state_n = ST_IDLE;
                end else begin
                    redirect_vld_n = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        block_n = (state_n != ST_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            o_block_commit <= 1'b0;
            o_squash       <= 1'b0;
            o_trap_wr      <= 1'b0;
            o_trap_is_intr <= 1'b0;
            o_trap_info    <= '0;
            o_mret_done    <= 1'b0;
            o_redirect_vld <= 1'b0;
            o_redirect_pc  <= '0;
            o_hang         <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            o_block_commit <= block_n;
            o_squash       <= squash_n;
            o_trap_wr      <= trap_wr_n;
            o_trap_is_intr <= is_intr_n;
            o_trap_info    <= info_n;
            o_mret_done    <= mret_done_n;
            o_redirect_vld <= redirect_vld_n;
            o_redirect_pc  <= target_n;
            o_hang         <= hang_n;
        end
    end

    // The ROB is blocked outside IDLE, so no commit event may appear there.
    a_no_commit_when_busy: assert property (@(posedge clk) disable iff (!rst)
        (state != ST_IDLE) |-> !(i_exc_vld || i_mret_vld));

endmodule

// File: tb/tb_trap_handler.sv
// tb_trap_handler: directed and randomized checks of trap_handler against a
// behavioural model of event selection and redirect targets.
module tb_trap_handler;
    import trap_handler_pkg::*;

    localparam int unsigned DRAIN = 8;
    localparam int K_EXC = 0, K_MRET = 1, K_INTR = 2, K_NONE = 3;
    localparam int INTR_PRIO [6] = '{11, 3, 7, 9, 1, 5};

    logic               clk = 1'b0;
    logic               rst;
    logic               i_exc_vld, i_mret_vld, i_head_vld, i_mstatus_mie;
    logic               i_backend_idle, i_redirect_rdy;
    logic [CAUSE_W-1:0] i_exc_cause;
    logic [XLEN-1:0]    i_exc_epc, i_exc_tval, i_head_pc, i_mtvec, i_mepc;
    logic [15:0]        i_mip, i_mie;
    logic               o_block_commit, o_squash, o_trap_wr, o_trap_is_intr;
    logic               o_mret_done, o_redirect_vld, o_hang;
    trapInfo_t          o_trap_info;
    logic [XLEN-1:0]    o_redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    trap_handler #(.DRAIN_TIMEOUT(DRAIN)) dut (
        .clk(clk), .rst(rst),
        .i_exc_vld(i_exc_vld), .i_exc_cause(i_exc_cause),
        .i_exc_epc(i_exc_epc), .i_exc_tval(i_exc_tval),
        .i_mret_vld(i_mret_vld), .i_head_vld(i_head_vld), .i_head_pc(i_head_pc),
        .i_mip(i_mip), .i_mie(i_mie), .i_mstatus_mie(i_mstatus_mie),
        .i_mtvec(i_mtvec), .i_mepc(i_mepc),
        .i_backend_idle(i_backend_idle), .i_redirect_rdy(i_redirect_rdy),
        .o_block_commit(o_block_commit), .o_squash(o_squash),
        .o_trap_wr(o_trap_wr), .o_trap_is_intr(o_trap_is_intr),
        .o_trap_info(o_trap_info), .o_mret_done(o_mret_done),
        .o_redirect_vld(o_redirect_vld), .o_redirect_pc(o_redirect_pc),
        .o_hang(o_hang)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_intr(input logic [15:0] pend);
        for (int i = 0; i < 6; i++) begin
            if (pend[INTR_PRIO[i]]) return 16'(INTR_PRIO[i]);
        end
        return 16'hFFFF;
    endfunction

    function automatic int model_event(input logic exc, input logic mret, input logic head,
                                       input logic gie, input logic [15:0] mip,
                                       input logic [15:0] mie);
        if (exc) return K_EXC;
        if (mret) return K_MRET;
        if (head && gie && model_intr(mip & mie) != 16'hFFFF) return K_INTR;
        return K_NONE;
    endfunction

    function automatic logic [31:0] model_target(input int kind, input logic [31:0] mtvec,
                                                 input logic [31:0] mepc, input logic [15:0] code);
        logic [31:0] base;
        if (kind == K_MRET) return mepc;
        base = mtvec & ~32'd3;
`ifdef TRAP_VECTORED_EN
        if (kind == K_INTR && (mtvec % 4) == 1) return base + 32'(code) * 4;
`endif
        return base;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_events();
        i_exc_vld = 1'b0; i_mret_vld = 1'b0; i_mip = '0; i_mie = '0;
        i_mstatus_mie = 1'b0; i_head_vld = 1'b0;
    endtask

    // Let the current sequence drain and redirect; ok=0 if it never returns to IDLE.
    task automatic finish_seq(output bit ok);
        ok = 1'b0;
        i_backend_idle = 1'b1; i_redirect_rdy = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (!o_block_commit) ok = 1'b1;
        end
        i_backend_idle = 1'b0; i_redirect_rdy = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        clear_events();
        i_exc_cause = '0; i_exc_epc = '0; i_exc_tval = '0; i_head_pc = '0;
        i_mtvec = '0; i_mepc = '0; i_backend_idle = 1'b0; i_redirect_rdy = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({o_block_commit, o_squash, o_trap_wr, o_trap_is_intr, o_mret_done,
             o_redirect_vld, o_hang} !== 7'b0 || o_trap_info !== '0 || o_redirect_pc !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got flags=%b info=%h pc=%h, expected all 0",
                     {o_block_commit, o_squash, o_trap_wr, o_trap_is_intr, o_mret_done,
                      o_redirect_vld, o_hang}, o_trap_info, o_redirect_pc);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (o_block_commit !== 1'b0 || o_squash !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got block=%b squash=%b, expected 0 0", o_block_commit, o_squash);
        end
    endtask

    task automatic test_exception();
        trapInfo_t exp;
        i_exc_vld = 1'b1; i_exc_cause = 16'd2; i_exc_epc = 32'h8000_0010;
        i_exc_tval = 32'h0000_0073; i_mtvec = 32'h8000_0100; i_backend_idle = 1'b1;
        exp.cause = 16'd2; exp.epc = 32'h8000_0010; exp.tval = 32'h0000_0073;
        n_tests++;
        if (o_block_commit !== 1'b0) begin
            n_fail++; $display("FAIL exc_block_T: got %b expected 0", o_block_commit);
        end
        @(negedge clk); // T+1
        i_exc_vld = 1'b0;
        n_tests++;
        if (o_squash !== 1'b1 || o_trap_wr !== 1'b1 || o_trap_is_intr !== 1'b0 ||
            o_trap_info !== exp || o_block_commit !== 1'b1 || o_mret_done !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_T1: got sq=%b wr=%b intr=%b info=%h blk=%b, expected 1 1 0 %h 1",
                     o_squash, o_trap_wr, o_trap_is_intr, o_trap_info, o_block_commit, exp);
        end
        @(negedge clk); // T+2
        n_tests++;
        if (o_squash !== 1'b0 || o_trap_wr !== 1'b0 || o_redirect_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_T2: got sq=%b wr=%b vld=%b, expected 0 0 0", o_squash, o_trap_wr, o_redirect_vld);
        end
        @(negedge clk); // T+3
        i_redirect_rdy = 1'b1;
        n_tests++;
        if (o_redirect_vld !== 1'b1 || o_redirect_pc !== 32'h8000_0100) begin
            n_fail++;
            $display("FAIL exc_T3: got vld=%b pc=%h, expected 1 80000100", o_redirect_vld, o_redirect_pc);
        end
        @(negedge clk); // T+4
        i_redirect_rdy = 1'b0; i_backend_idle = 1'b0;
        n_tests++;
        if (o_redirect_vld !== 1'b0 || o_block_commit !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_T4: got vld=%b blk=%b, expected 0 0", o_redirect_vld, o_block_commit);
        end
    endtask

    task automatic test_interrupt_priority();
        trapInfo_t exp;
        logic [31:0] tgt;
        i_mip = 16'h0888; i_mie = 16'h0888; i_mstatus_mie = 1'b1; i_head_vld = 1'b1;
        i_head_pc = 32'h8000_2000; i_mtvec = 32'h8000_0101; i_backend_idle = 1'b1;
        exp.cause = model_intr(i_mip & i_mie); exp.epc = i_head_pc; exp.tval = '0;
        tgt = model_target(K_INTR, i_mtvec, i_mepc, exp.cause);
        @(negedge clk); // T+1
        clear_events();
        n_tests++;
        if (o_trap_wr !== 1'b1 || o_trap_is_intr !== 1'b1 || o_trap_info !== exp) begin
            n_fail++;
            $display("FAIL intr_prio: got wr=%b intr=%b info=%h, expected 1 1 %h",
                     o_trap_wr, o_trap_is_intr, o_trap_info, exp);
        end
        repeat (2) @(negedge clk); // T+3
        i_redirect_rdy = 1'b1;
        n_tests++;
        if (o_redirect_vld !== 1'b1 || o_redirect_pc !== tgt) begin
            n_fail++;
            $display("FAIL intr_target: got vld=%b pc=%h, expected 1 %h", o_redirect_vld, o_redirect_pc, tgt);
        end
        @(negedge clk);
        i_redirect_rdy = 1'b0; i_backend_idle = 1'b0;
    endtask

    task automatic test_masking();
        bit quiet = 1'b1;
        bit ok;
        i_mip = 16'h0080; i_mie = 16'h0080; i_mstatus_mie = 1'b0; i_head_vld = 1'b1;
        i_head_pc = 32'h8000_3000;
        repeat (20) begin
            @(negedge clk);
            if (o_squash || o_trap_wr || o_block_commit || o_redirect_vld || o_mret_done) quiet = 1'b0;
        end
        n_tests++;
        if (!quiet) begin
            n_fail++; $display("FAIL mask_quiet: got activity=1 expected 0 with mstatus_mie=0");
        end
        i_mstatus_mie = 1'b1;
        @(negedge clk);
        clear_events();
        n_tests++;
        if (o_trap_wr !== 1'b1 || o_trap_info.cause !== model_intr(16'h0080) || o_trap_is_intr !== 1'b1) begin
            n_fail++;
            $display("FAIL mask_enable: got wr=%b cause=%0d, expected 1 7", o_trap_wr, o_trap_info.cause);
        end
        finish_seq(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL mask_drain: got busy expected idle"); end
    endtask

    task automatic test_collision();
        bit got, ok;
        i_exc_vld = 1'b1; i_exc_cause = 16'd5; i_exc_epc = 32'h8000_0500; i_exc_tval = 32'h1;
        i_mip = 16'h0800; i_mie = 16'h0800; i_mstatus_mie = 1'b1; i_head_vld = 1'b1;
        i_head_pc = 32'h8000_0600;
        @(negedge clk);
        i_exc_vld = 1'b0; i_backend_idle = 1'b1; i_redirect_rdy = 1'b1;
        n_tests++;
        if (o_trap_wr !== 1'b1 || o_trap_is_intr !== 1'b0 || o_trap_info.cause !== 16'd5) begin
            n_fail++;
            $display("FAIL coll_exc_first: got wr=%b intr=%b cause=%0d, expected 1 0 5",
                     o_trap_wr, o_trap_is_intr, o_trap_info.cause);
        end
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (o_trap_wr) got = 1'b1;
        end
        clear_events();
        n_tests++;
        if (!got || o_trap_is_intr !== 1'b1 || o_trap_info.cause !== 16'd11 ||
            o_trap_info.epc !== 32'h8000_0600) begin
            n_fail++;
            $display("FAIL coll_intr_after: got seen=%b intr=%b cause=%0d epc=%h, expected 1 1 11 80000600",
                     got, o_trap_is_intr, o_trap_info.cause, o_trap_info.epc);
        end
        finish_seq(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL coll_drain: got busy expected idle"); end
    endtask

    task automatic test_mret_stall();
        i_mret_vld = 1'b1; i_mepc = 32'h8000_4444; i_backend_idle = 1'b1; i_redirect_rdy = 1'b0;
        @(negedge clk); // T+1
        i_mret_vld = 1'b0;
        n_tests++;
        if (o_mret_done !== 1'b1 || o_trap_wr !== 1'b0 || o_squash !== 1'b1) begin
            n_fail++;
            $display("FAIL mret_T1: got done=%b wr=%b sq=%b, expected 1 0 1", o_mret_done, o_trap_wr, o_squash);
        end
        @(negedge clk); // T+2
        n_tests++;
        if (o_mret_done !== 1'b0) begin
            n_fail++; $display("FAIL mret_pulse: got done=%b expected 0", o_mret_done);
        end
        @(negedge clk); // T+3
        i_mepc = 32'h1234_5678;
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if (o_redirect_vld !== 1'b1 || o_redirect_pc !== 32'h8000_4444) begin
                n_fail++;
                $display("FAIL mret_hold[%0d]: got vld=%b pc=%h, expected 1 80004444", k, o_redirect_vld, o_redirect_pc);
            end
            if (k < 5) @(negedge clk);
        end
        i_redirect_rdy = 1'b1;
        @(negedge clk);
        i_redirect_rdy = 1'b0; i_backend_idle = 1'b0;
        n_tests++;
        if (o_redirect_vld !== 1'b0 || o_block_commit !== 1'b0) begin
            n_fail++;
            $display("FAIL mret_release: got vld=%b blk=%b, expected 0 0", o_redirect_vld, o_block_commit);
        end
    endtask

    task automatic test_random();
        int kind, d, r;
        logic [15:0] code;
        logic [31:0] tgt;
        trapInfo_t exp;
        int idx;
        for (int it = 0; it < 40; it++) begin
            i_redirect_rdy = 1'b0; i_backend_idle = 1'b0;
            i_exc_vld = 1'b0; i_mret_vld = 1'b0;
            i_exc_cause = 16'($urandom); i_exc_epc = $urandom; i_exc_tval = $urandom;
            i_head_pc = $urandom; i_mepc = $urandom;
            i_mtvec = ($urandom & ~32'd3) | 32'($urandom_range(0, 1));
            i_mip = 16'($urandom); i_mie = 16'($urandom);
            i_mstatus_mie = 1'($urandom); i_head_vld = 1'($urandom);
            case ($urandom_range(0, 2))
                0: begin i_exc_vld = 1'b1; i_mret_vld = 1'($urandom); end
                1: i_mret_vld = 1'b1;
                default: begin
                    idx = int'($urandom_range(0, 5));
                    i_mip = i_mip | (16'd1 << INTR_PRIO[idx]);
                    i_mie = i_mie | (16'd1 << INTR_PRIO[idx]);
                    i_head_vld = 1'b1; i_mstatus_mie = 1'b1;
                end
            endcase
            kind = model_event(i_exc_vld, i_mret_vld, i_head_vld, i_mstatus_mie, i_mip, i_mie);
            code = model_intr(i_mip & i_mie);
            exp.cause = (kind == K_EXC) ? i_exc_cause : code;
            exp.epc   = (kind == K_EXC) ? i_exc_epc : i_head_pc;
            exp.tval  = (kind == K_EXC) ? i_exc_tval : '0;
            tgt = model_target(kind, i_mtvec, i_mepc, code);
            n_tests++;
            if (o_block_commit !== 1'b0) begin
                n_fail++; $display("FAIL rnd%0d_idle: got blk=%b expected 0", it, o_block_commit);
            end
            @(negedge clk); // T+1
            i_exc_vld = 1'b0; i_mret_vld = 1'b0; i_mip = '0;
            i_mtvec = $urandom; i_mepc = $urandom; i_backend_idle = 1'($urandom);
            n_tests++;
            if (o_squash !== 1'b1 || o_trap_wr !== (kind != K_MRET) ||
                o_mret_done !== (kind == K_MRET) || o_block_commit !== 1'b1 ||
                (kind != K_MRET && (o_trap_info !== exp || o_trap_is_intr !== (kind == K_INTR)))) begin
                n_fail++;
                $display("FAIL rnd%0d_accept: got sq=%b wr=%b done=%b intr=%b info=%h, expected kind=%0d info=%h",
                         it, o_squash, o_trap_wr, o_mret_done, o_trap_is_intr, o_trap_info, kind, exp);
            end
            d = int'($urandom_range(0, 4));
            r = int'($urandom_range(0, 3));
            for (int k = 2; k <= 2 + d; k++) begin
                @(negedge clk);
                i_backend_idle = (k == 2 + d);
                n_tests++;
                if (o_redirect_vld !== 1'b0 || o_squash !== 1'b0 || o_trap_wr !== 1'b0 ||
                    o_mret_done !== 1'b0 || o_block_commit !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rnd%0d_flush: got vld=%b sq=%b wr=%b blk=%b, expected 0 0 0 1",
                             it, o_redirect_vld, o_squash, o_trap_wr, o_block_commit);
                end
            end
            for (int k = 0; k <= r; k++) begin
                @(negedge clk);
                i_backend_idle = 1'b0;
                n_tests++;
                if (o_redirect_vld !== 1'b1 || o_redirect_pc !== tgt) begin
                    n_fail++;
                    $display("FAIL rnd%0d_redirect: got vld=%b pc=%h, expected 1 %h",
                             it, o_redirect_vld, o_redirect_pc, tgt);
                end
            end
            i_redirect_rdy = 1'b1;
            @(negedge clk);
            i_redirect_rdy = 1'b0;
            n_tests++;
            if (o_redirect_vld !== 1'b0 || o_block_commit !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd%0d_done: got vld=%b blk=%b, expected 0 0", it, o_redirect_vld, o_block_commit);
            end
        end
        clear_events();
        n_tests++;
        if (o_hang !== 1'b0) begin
            n_fail++; $display("FAIL rnd_no_hang: got %b expected 0", o_hang);
        end
    endtask

    task automatic test_hang_reset();
        i_exc_vld = 1'b1; i_exc_cause = 16'd1; i_mtvec = 32'h8000_0000; i_backend_idle = 1'b0;
        @(negedge clk); // T+1
        i_exc_vld = 1'b0;
        repeat (7) @(negedge clk); // T+8
        n_tests++;
        if (o_hang !== 1'b0 || o_block_commit !== 1'b1) begin
            n_fail++; $display("FAIL hang_early: got hang=%b blk=%b, expected 0 1", o_hang, o_block_commit);
        end
        @(negedge clk); // T+9
        n_tests++;
        if (o_hang !== 1'b1 || o_block_commit !== 1'b1 || o_redirect_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL hang_set: got hang=%b blk=%b vld=%b, expected 1 1 0", o_hang, o_block_commit, o_redirect_vld);
        end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({o_block_commit, o_squash, o_trap_wr, o_trap_is_intr, o_mret_done,
             o_redirect_vld, o_hang} !== 7'b0 || o_trap_info !== '0 || o_redirect_pc !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got flags=%b info=%h pc=%h, expected all 0",
                     {o_block_commit, o_squash, o_trap_wr, o_trap_is_intr, o_mret_done,
                      o_redirect_vld, o_hang}, o_trap_info, o_redirect_pc);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (o_block_commit !== 1'b0 || o_hang !== 1'b0) begin
            n_fail++; $display("FAIL post_reset: got blk=%b hang=%b, expected 0 0", o_block_commit, o_hang);
        end
    endtask

    initial begin
        test_reset();
        test_exception();
        test_interrupt_priority();
        test_masking();
        test_collision();
        test_mret_stall();
        test_random();
        test_hang_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
